// File: rtl/bf8b_pkg.sv
// rtl/bf8b_pkg.sv - shared types and defaults for the eightbit memory/loader slice
//
// Purpose: default bus widths, loader FSM state type and bus word typedefs
// used by bf8b_mem_loader and bf8b_ram_sp.
// Ports: none (package).
package bf8b_pkg;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } ld_state_t;

  typedef logic [DEFAULT_ADDR_W-1:0] addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] data_t;

endpackage

// File: rtl/bf8b_ram_sp.sv
// rtl/bf8b_ram_sp.sv - single-port write-first RAM with one-cycle registered read
//
// Purpose: storage array for the eightbit core. A write also returns the
// written word on the read port at the same edge (write-first). The array
// and the read register are not reset.
// Ports:
//   clk    in   clock, all state on posedge
//   we     in   write enable
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data (1-cycle latency)
module bf8b_ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_comb begin
    rdata_d = mem[addr];
    if (we) begin
      rdata_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bf8b_mem_loader.sv
// rtl/bf8b_mem_loader.sv - program/data RAM with byte-stream boot loader for the eightbit core
//
// Purpose: serves the core's addr/data/we bus from a synchronous RAM. After
// reset (or an ld_start pulse while running) the core is held off and the RAM
// is filled from address 0 by a ready/valid byte stream; the core is released
// after the last byte or after the top address has been written.
// Ports:
//   clk         in   clock, all state on posedge
//   rst         in   asynchronous active-high reset
//   addr        in   core address
//   data_in     in   core write data
//   data_out    out  read data to core, 1-cycle latency, 0 while loading
//   we          in   core write enable
//   ld_valid    in   loader byte valid
//   ld_ready    out  loader can accept a byte
//   ld_data     in   loader byte
//   ld_last     in   final loader byte marker
//   ld_start    in   pulse while running to re-enter loading
//   cpu_hold    out  core must stall while high
//   load_count  out  bytes written by the most recent load
module bf8b_mem_loader
  import bf8b_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  input  logic              we,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic              ld_start,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

  ld_state_t         state_d, state_q;
  logic [ADDR_W-1:0] load_ptr_d, load_ptr_q;
  logic [ADDR_W:0]   load_count_d, load_count_q;
  logic              ld_ready_d, ld_ready_q;
  logic              cpu_hold_d, cpu_hold_q;
  logic              out_en_d, out_en_q;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    load_count_d = load_count_q;
    ram_we       = 1'b0;
    ram_addr     = addr;
    ram_wdata    = data_in;

    case (state_q)
      LOAD: begin
        // The loader owns the RAM port; core we/addr are ignored.
        ram_addr  = load_ptr_q;
        ram_wdata = ld_data;
        if (ld_valid && ld_ready_q) begin
          ram_we       = 1'b1;
          load_ptr_d   = load_ptr_q + ADDR_W'(1);
          load_count_d = {1'b0, load_ptr_q} + (ADDR_W+1)'(1);
          // Writing the top address ends the load even without ld_last, so
          // the pointer never wraps back over already loaded bytes.
          if (ld_last || (load_ptr_q == PTR_MAX)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // A core write in the ld_start cycle still commits.
        ram_we = we;
        if (ld_start) begin
          state_d      = LOAD;
          load_ptr_d   = '0;
          load_count_d = '0;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // ld_ready drops on the accepting edge so no byte is offered to a RUN
    // state; cpu_hold rises with entry to LOAD but falls one clock after
    // exit, giving the core a clean cycle before it is released.
    ld_ready_d = (state_d == LOAD);
    cpu_hold_d = (state_d == LOAD) || (state_q == LOAD);
    // Read data is only forwarded for core accesses in steady RUN.
    out_en_d   = (state_q == RUN) && !ld_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      load_ptr_q   <= '0;
      load_count_q <= '0;
      ld_ready_q   <= 1'b1;
      cpu_hold_q   <= 1'b1;
      out_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      load_count_q <= load_count_d;
      ld_ready_q   <= ld_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      out_en_q     <= out_en_d;
    end
  end

  bf8b_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign data_out   = out_en_q ? ram_rdata : '0;
  assign ld_ready   = ld_ready_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_count = load_count_q;

endmodule
